// File: rtl/alarm_annunciator.sv
// ============================================================================
// Module   : alarm_annunciator
// Brief    : 8-channel alarm annunciator with acknowledge, blinking lamps and
//            a 7-segment display of the highest-priority channel.
//            Optional macro RINGBACK_EN adds the RINGBACK channel state.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alarm_annunciator #(
  parameter int BLINK_DIV = 4
) (
  input  logic       clk_2,
  input  logic       reset,
  input  logic [7:0] req,
  input  logic       ack,
  output logic [7:0] active,
  output logic [7:0] LED,
  output logic [7:0] SEG,
  output logic       horn
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ALARM    = 2'd1,
    ST_ACKED    = 2'd2
`ifdef RINGBACK_EN
    , ST_RINGBACK = 2'd3
`endif
  } state_t;

  localparam logic [7:0] c_CNT_LAST = 8'(BLINK_DIV - 1);

  state_t     r_state [8];
  state_t     w_next  [8];
  logic       r_ack_s1, r_ack_s2, r_ack_s3, r_ack_evt;
  logic [7:0] r_cnt;
  logic       r_fast;
`ifdef RINGBACK_EN
  logic       r_slow;
`endif

  // The edge pulse is registered so channels act on it one edge after detection.
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      r_ack_s1  <= 1'b0;
      r_ack_s2  <= 1'b0;
      r_ack_s3  <= 1'b0;
      r_ack_evt <= 1'b0;
    end else begin
      r_ack_s1  <= ack;
      r_ack_s2  <= r_ack_s1;
      r_ack_s3  <= r_ack_s2;
      r_ack_evt <= r_ack_s2 & ~r_ack_s3;
    end
  end

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      r_cnt  <= 8'd0;
      r_fast <= 1'b0;
`ifdef RINGBACK_EN
      r_slow <= 1'b0;
`endif
    end else if (r_cnt == c_CNT_LAST) begin
      r_cnt  <= 8'd0;
      r_fast <= ~r_fast;
`ifdef RINGBACK_EN
      if (r_fast) r_slow <= ~r_slow;
`endif
    end else begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) r_state[i] <= ST_IDLE;
    end else begin
      for (int i = 0; i < 8; i++) r_state[i] <= w_next[i];
    end
  end

  // A new request on an IDLE channel wins over a coincident acknowledge.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      w_next[i] = r_state[i];
      case (r_state[i])
        ST_IDLE:  if (req[i]) w_next[i] = ST_ALARM;
        ST_ALARM: if (r_ack_evt) w_next[i] = req[i] ? ST_ACKED : ST_IDLE;
`ifdef RINGBACK_EN
        ST_ACKED: if (!req[i]) w_next[i] = ST_RINGBACK;
        ST_RINGBACK: begin
          if (req[i])         w_next[i] = ST_ALARM;
          else if (r_ack_evt) w_next[i] = ST_IDLE;
        end
`else
        ST_ACKED: if (!req[i]) w_next[i] = ST_IDLE;
`endif
        default:  w_next[i] = ST_IDLE;
      endcase
    end
  end

  function automatic logic [6:0] f_digit(input logic [2:0] ch);
    case (ch)
      3'd0:    f_digit = 7'h3F;
      3'd1:    f_digit = 7'h06;
      3'd2:    f_digit = 7'h5B;
      3'd3:    f_digit = 7'h4F;
      3'd4:    f_digit = 7'h66;
      3'd5:    f_digit = 7'h6D;
      3'd6:    f_digit = 7'h7D;
      default: f_digit = 7'h07;
    endcase
  endfunction

  logic       w_any_alarm, w_any_hold;
  logic [2:0] w_alarm_idx, w_hold_idx;

  // Scan downward so the lowest-index channel is the one left selected.
  always_comb begin
    active      = 8'd0;
    LED         = 8'd0;
    w_any_alarm = 1'b0;
    w_any_hold  = 1'b0;
    w_alarm_idx = 3'd0;
    w_hold_idx  = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      active[i] = (r_state[i] != ST_IDLE);
      case (r_state[i])
        ST_ALARM: begin
          LED[i]      = r_fast;
          w_any_alarm = 1'b1;
          w_alarm_idx = 3'(i);
        end
        ST_ACKED: begin
          LED[i]     = 1'b1;
          w_any_hold = 1'b1;
          w_hold_idx = 3'(i);
        end
`ifdef RINGBACK_EN
        ST_RINGBACK: begin
          LED[i]     = r_slow;
          w_any_hold = 1'b1;
          w_hold_idx = 3'(i);
        end
`endif
        default: LED[i] = 1'b0;
      endcase
    end
    horn = w_any_alarm;
    if (w_any_alarm)     SEG = {1'b1, f_digit(w_alarm_idx)};
    else if (w_any_hold) SEG = {1'b0, f_digit(w_hold_idx)};
    else                 SEG = 8'h00;
  end

endmodule

`default_nettype wire

// File: tb/tb_alarm_annunciator.sv
// ============================================================================
// Module   : tb_alarm_annunciator
// Brief    : Self-checking bench for alarm_annunciator (vectors + model).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alarm_annunciator;

  localparam int DIV = 4;

  logic       clk_2 = 1'b0;
  logic       reset;
  logic [7:0] req;
  logic       ack;
  logic [7:0] active, LED, SEG;
  logic       horn;

  int errors = 0;
  int checks = 0;

  alarm_annunciator #(.BLINK_DIV(DIV)) dut (
    .clk_2 (clk_2),
    .reset (reset),
    .req   (req),
    .ack   (ack),
    .active(active),
    .LED   (LED),
    .SEG   (SEG),
    .horn  (horn)
  );

  always #5 clk_2 = ~clk_2;

  // Reference model: 0 idle, 1 alarm, 2 acked, 3 ringback
  int ms [8];
  bit ah [4];   // ack samples at the last four edges, [0] most recent
  int mc;       // edges since reset release

  typedef struct {
    logic [7:0] req;
    logic       ack;
    logic [7:0] e_active;
    logic [7:0] e_led;
    logic [7:0] e_seg;
    logic       e_horn;
  } vec_t;

  vec_t tbl [29];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) ms[i] = 0;
    for (int i = 0; i < 4; i++) ah[i] = 1'b0;
    mc = 0;
  endtask

  task automatic model_edge(input logic [7:0] r, input logic a);
    bit evt;
    evt = ah[2] && !ah[3];
    for (int i = 0; i < 8; i++) begin
      case (ms[i])
        0: if (r[i]) ms[i] = 1;
        1: if (evt) ms[i] = r[i] ? 2 : 0;
`ifdef RINGBACK_EN
        2: if (!r[i]) ms[i] = 3;
`else
        2: if (!r[i]) ms[i] = 0;
`endif
        3: if (r[i]) ms[i] = 1; else if (evt) ms[i] = 0;
        default: ms[i] = 0;
      endcase
    end
    ah[3] = ah[2]; ah[2] = ah[1]; ah[1] = ah[0]; ah[0] = a;
    mc++;
  endtask

  function automatic logic [6:0] digit(input int ch);
    case (ch)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      default: return 7'h07;
    endcase
  endfunction

  task automatic check_model(input string tag);
    logic [7:0] ea, el, es;
    logic eh, fast, slow;
    int disp;
    fast = ((mc / DIV) % 2) == 1;
    slow = ((mc / (2 * DIV)) % 2) == 1;
    ea = 8'd0; el = 8'd0; eh = 1'b0; disp = -1;
    for (int i = 0; i < 8; i++) begin
      ea[i] = (ms[i] != 0);
      el[i] = (ms[i] == 1) ? fast : (ms[i] == 2) ? 1'b1 : (ms[i] == 3) ? slow : 1'b0;
      if (ms[i] == 1) eh = 1'b1;
    end
    for (int i = 0; i < 8; i++) if (disp < 0 && ms[i] == 1) disp = i;
    for (int i = 0; i < 8; i++) if (disp < 0 && ms[i] >= 2) disp = i;
    es = (disp < 0) ? {eh, 7'h00} : {eh, digit(disp)};
    chk({tag, " model active"}, active, ea);
    chk({tag, " model LED"}, LED, el);
    chk({tag, " model SEG"}, SEG, es);
    chk({tag, " model horn"}, {7'd0, horn}, {7'd0, eh});
  endtask

  task automatic cycle(input logic [7:0] r, input logic a);
    req = r;
    ack = a;
    @(posedge clk_2);
    model_edge(r, a);
    @(negedge clk_2);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " active"}, active, 8'h00);
    chk({tag, " LED"}, LED, 8'h00);
    chk({tag, " SEG"}, SEG, 8'h00);
    chk({tag, " horn"}, {7'd0, horn}, 8'h00);
  endtask

  task automatic do_reset(input logic a);
    req = 8'h00;
    ack = a;
    @(negedge clk_2);
    reset = 1'b1;
    model_reset();
    @(negedge clk_2);
    check_zero("in_reset");
    @(negedge clk_2);
    reset = 1'b0;
  endtask

  task automatic fill(input int k, input logic [7:0] r, input logic a, input logic [7:0] ea,
                      input logic [7:0] el, input logic [7:0] es, input logic eh);
    tbl[k].req = r; tbl[k].ack = a; tbl[k].e_active = ea;
    tbl[k].e_led = el; tbl[k].e_seg = es; tbl[k].e_horn = eh;
  endtask

  initial begin
    reset = 1'b1;
    req   = 8'h00;
    ack   = 1'b0;
    model_reset();

    //      req    ack  active LED    SEG    horn
    fill( 0, 8'h04, 0, 8'h04, 8'h00, 8'hDB, 1);
    fill( 1, 8'h00, 0, 8'h04, 8'h00, 8'hDB, 1);
    fill( 2, 8'h00, 0, 8'h04, 8'h00, 8'hDB, 1);
    fill( 3, 8'h00, 0, 8'h04, 8'h04, 8'hDB, 1);
    fill( 4, 8'h00, 0, 8'h04, 8'h04, 8'hDB, 1);
    fill( 5, 8'h00, 0, 8'h04, 8'h04, 8'hDB, 1);
    fill( 6, 8'h00, 0, 8'h04, 8'h04, 8'hDB, 1);
    fill( 7, 8'h00, 0, 8'h04, 8'h00, 8'hDB, 1);
    fill( 8, 8'h00, 1, 8'h04, 8'h00, 8'hDB, 1);
    fill( 9, 8'h00, 1, 8'h04, 8'h00, 8'hDB, 1);
    fill(10, 8'h00, 0, 8'h04, 8'h00, 8'hDB, 1);
    fill(11, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0);
    fill(12, 8'h04, 0, 8'h04, 8'h04, 8'hDB, 1);
    fill(13, 8'h04, 1, 8'h04, 8'h04, 8'hDB, 1);
    fill(14, 8'h04, 0, 8'h04, 8'h04, 8'hDB, 1);
    fill(15, 8'h04, 0, 8'h04, 8'h00, 8'hDB, 1);
    fill(16, 8'h04, 0, 8'h04, 8'h04, 8'h5B, 0);
    fill(17, 8'h04, 0, 8'h04, 8'h04, 8'h5B, 0);
    fill(18, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0);
    fill(19, 8'h81, 0, 8'h81, 8'h81, 8'hBF, 1);
    fill(20, 8'h80, 1, 8'h81, 8'h81, 8'hBF, 1);
    fill(21, 8'h80, 0, 8'h81, 8'h81, 8'hBF, 1);
    fill(22, 8'h80, 0, 8'h81, 8'h81, 8'hBF, 1);
    fill(23, 8'h80, 0, 8'h80, 8'h80, 8'h07, 0);
    fill(24, 8'h80, 1, 8'h80, 8'h80, 8'h07, 0);
    fill(25, 8'h80, 0, 8'h80, 8'h80, 8'h07, 0);
    fill(26, 8'h80, 0, 8'h80, 8'h80, 8'h07, 0);
    fill(27, 8'hA0, 0, 8'hA0, 8'hA0, 8'hED, 1);
    fill(28, 8'hA0, 0, 8'hA0, 8'hA0, 8'hED, 1);

    @(negedge clk_2);
    check_zero("por");
    @(negedge clk_2);
    reset = 1'b0;

`ifndef RINGBACK_EN
    for (int k = 0; k < 29; k++) begin
      string tag;
      tag = $sformatf("vec%0d", k);
      cycle(tbl[k].req, tbl[k].ack);
      chk({tag, " active"}, active, tbl[k].e_active);
      chk({tag, " LED"}, LED, tbl[k].e_led);
      chk({tag, " SEG"}, SEG, tbl[k].e_seg);
      chk({tag, " horn"}, {7'd0, horn}, {7'd0, tbl[k].e_horn});
      check_model(tag);
    end
`else
    // Ringback: ch1 acknowledged, request drops, slow blink, second ack clears
    cycle(8'h02, 1'b0);
    cycle(8'h02, 1'b1);
    for (int k = 0; k < 3; k++) cycle(8'h02, 1'b0);
    check_model("rb_acked");
    for (int k = 0; k < 20; k++) begin
      cycle(8'h00, 1'b0);
      check_model("rb_blink");
      chk("rb_horn", {7'd0, horn}, 8'h00);
    end
    cycle(8'h00, 1'b1);
    for (int k = 0; k < 3; k++) cycle(8'h00, 1'b0);
    chk("rb_cleared active", active, 8'h00);
    check_model("rb_cleared");
`endif

    // Asynchronous reset mid-alarm: outputs clear before the next edge
    cycle(8'h10, 1'b0);
    chk("pre_areset horn", {7'd0, horn}, 8'h01);
    @(posedge clk_2);
    model_edge(8'h10, 1'b0);
    #2 reset = 1'b1;
    #1 check_zero("areset");
    model_reset();

    // Ack held through reset release yields exactly one acknowledge
    ack = 1'b1;
    @(negedge clk_2);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle(8'h02, 1'b1);
      check_model("ackhold");
    end
    chk("ackhold alarm horn", {7'd0, horn}, 8'h01);
    cycle(8'h02, 1'b1);
    chk("ackhold acked horn", {7'd0, horn}, 8'h00);
    chk("ackhold acked active", active, 8'h02);
    cycle(8'h00, 1'b1);
    check_model("ackhold drop");
    for (int k = 0; k < 6; k++) begin
      cycle(8'h02, 1'b1);
      check_model("ackhold realarm");
    end
    chk("ackhold single evt horn", {7'd0, horn}, 8'h01);

    // Randomized traffic against the model
    do_reset(1'b0);
    begin
      logic a;
      a = 1'b0;
      for (int n = 0; n < 500; n++) begin
        if ($urandom_range(0, 5) == 0) a = ~a;
        if ($urandom_range(0, 120) == 0) do_reset(a);
        cycle(8'($urandom & $urandom & $urandom), a);
        check_model($sformatf("rand%0d", n));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alarm_annunciator.md
ALARM_ANNUNCIATOR -- requirements
Module: alarm_annunciator

Interface
REQ-001 The block SHALL have parameter BLINK_DIV, default 4: the fast-blink phase toggles every BLINK_DIV clk_2 cycles, legal range 2..255.
REQ-002 The block SHALL have port clk_2, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port req, input, 8 bits: per-channel alarm request levels, synchronous to clk_2 (e.g. sirene, alarme).
REQ-005 The block SHALL have port ack, input, 1 bit: operator acknowledge button level, asynchronous to clk_2.
REQ-006 The block SHALL have port active, output, 8 bits: bit i = 1 when channel i is not IDLE.
REQ-007 The block SHALL have port LED, output, 8 bits: per-channel annunciator lamp.
REQ-008 The block SHALL have port SEG, output, 8 bits: SEG[6:0] = gfedcba active-high digit of the displayed channel; SEG[7] = horn.
REQ-009 The block SHALL have port horn, output, 1 bit: 1 when any channel is in ALARM.

Function
REQ-010 The block SHALL keep one state per channel: IDLE, ALARM, ACKED and (RINGBACK_EN only) RINGBACK.
REQ-011 The block SHALL synchronise ack through 2 flops, then produce a 1-cycle ack_evt on the rising edge of the synchronised level; with ack rising before edge N, ack_evt is high between edges N+2 and N+3, and states update at edge N+3.
REQ-012 The block SHALL move IDLE to ALARM on the first edge where req[i]=1.
REQ-013 The block SHALL hold ALARM while req[i] is deasserted (latched) until ack_evt.
REQ-014 On ack_evt, ALARM SHALL go to ACKED if req[i]=1, else to IDLE.
REQ-015 ACKED SHALL go to IDLE when req[i]=0 (without RINGBACK_EN).
REQ-016 When ack_evt and req[i] rising coincide on an IDLE channel, the channel SHALL go to ALARM; a coincident ack SHALL NOT acknowledge a new alarm.
REQ-017 A single ack_evt SHALL act on all channels simultaneously.
REQ-018 The blink counter SHALL count 0..BLINK_DIV-1 and wrap; fast phase toggles at wrap; slow phase toggles on every second fast-phase toggle.
REQ-019 LED[i] SHALL be: IDLE=0, ALARM=fast phase, ACKED=1, RINGBACK=slow phase.
REQ-020 The displayed channel SHALL be the lowest-index channel in ALARM, else the lowest-index channel in ACKED/RINGBACK, else none, in which case SEG[6:0]=0.
REQ-021 Digits SHALL be encoded as 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07 (hex).
REQ-022 active, LED, SEG and horn SHALL be decoded from registered state with no added cycle latency.

Reset
REQ-023 Reset SHALL immediately force all channels IDLE, the counter to 0, both blink phases to 0, and the sync/edge flops to 0; all outputs SHALL then read 0.
REQ-024 If ack is held high through reset release, the block SHALL produce exactly one ack_evt afterwards; it acts only on channels that are non-IDLE at that time.
REQ-025 Reset asserted mid-blink or mid-sync SHALL discard all pending events.

Configuration
REQ-026 With macro RINGBACK_EN defined, ACKED SHALL go to RINGBACK when req[i]=0; RINGBACK SHALL go to ALARM if req[i] returns to 1, go to IDLE on ack_evt, and never drive horn.
REQ-027 With RINGBACK_EN undefined, the RINGBACK state SHALL NOT exist and REQ-015 applies.

Verification
REQ-028 Bench SHALL cover: req=0x04 for 1 cycle -> active=0x04, horn=1, SEG=0xDB, LED[2] toggles every 4 cycles; persists with req=0.
REQ-029 Bench SHALL cover: ALARM on ch2, req held 1, ack pulse -> ACKED 3 edges later, LED[2]=1 steady, horn=0, SEG=0x5B; then req=0 -> IDLE (without RINGBACK_EN), all outputs 0.
REQ-030 Bench SHALL cover: req=0x81 simultaneously -> SEG[6:0]=0x3F (channel 0 shown); ack with req=0x80 -> active=0x80, SEG=0x07.
REQ-031 Bench SHALL cover: ack_evt coincident with a new req[5] rise -> ch5 in ALARM, horn=1.
REQ-032 Bench SHALL cover: with RINGBACK_EN, ACKED ch1, req[1]=0 -> LED[1] toggles every 8 cycles, horn=0; second ack -> IDLE.
REQ-033 Bench SHALL cover: reset asserted mid-ALARM asynchronously -> outputs 0 before the next clk_2 edge.
